// File: rtl/sorter_pkg.sv
// Shared definitions for the 8-bit signed sorter and its output-stream checker.
// Frame geometry, the sample type and the checker state encoding live here.
package sorter_pkg;

  localparam int DW        = 8;
  localparam int FRAME_LEN = 8;
  localparam int SW        = DW + $clog2(FRAME_LEN);

  typedef logic signed [DW-1:0] sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

endpackage

// File: rtl/sorted_frame_checker.sv
// Receive-side monitor for the sorter output burst: checks each frame is
// non-decreasing and contiguous, and reports min/max/sum/pass per frame.
module sorted_frame_checker #(
  parameter int FRAME_LEN = sorter_pkg::FRAME_LEN,
  parameter int DW        = sorter_pkg::DW,
  parameter int SW        = DW + $clog2(FRAME_LEN)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 clear_err,
  output logic                 frame_done,
  output logic                 frame_ok,
  output logic signed [DW-1:0] frame_min,
  output logic signed [DW-1:0] frame_max,
  output logic signed [SW-1:0] frame_sum,
  output logic [15:0]          frame_cnt,
  output logic                 order_err,
  output logic                 gap_err,
  output logic                 err_sticky
);

  import sorter_pkg::state_e;
  import sorter_pkg::IDLE;
  import sorter_pkg::RECV;

  localparam int             IW       = $clog2(FRAME_LEN);
  localparam logic [IW-1:0]  LAST_IDX = IW'(FRAME_LEN - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [DW-1:0] min_q, min_d;
  logic signed [DW-1:0] max_q, max_d;
  logic signed [DW-1:0] prev_q, prev_d;
  logic signed [SW-1:0] sum_q, sum_d;
  logic                 ok_q, ok_d;

  logic                 frame_done_q, frame_done_d;
  logic                 frame_ok_q, frame_ok_d;
  logic signed [DW-1:0] frame_min_q, frame_min_d;
  logic signed [DW-1:0] frame_max_q, frame_max_d;
  logic signed [SW-1:0] frame_sum_q, frame_sum_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 order_err_q, order_err_d;
  logic                 gap_err_q, gap_err_d;
  logic                 err_sticky_q, err_sticky_d;

  logic signed [SW-1:0] samp_ext_s;

  assign samp_ext_s = {{(SW-DW){in_data[DW-1]}}, in_data};

  // State, accumulator and published-report registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      idx_q        <= {IW{1'b0}};
      min_q        <= {DW{1'b0}};
      max_q        <= {DW{1'b0}};
      prev_q       <= {DW{1'b0}};
      sum_q        <= {SW{1'b0}};
      ok_q         <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_min_q  <= {DW{1'b0}};
      frame_max_q  <= {DW{1'b0}};
      frame_sum_q  <= {SW{1'b0}};
      frame_cnt_q  <= 16'd0;
      order_err_q  <= 1'b0;
      gap_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      min_q        <= min_d;
      max_q        <= max_d;
      prev_q       <= prev_d;
      sum_q        <= sum_d;
      ok_q         <= ok_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      frame_min_q  <= frame_min_d;
      frame_max_q  <= frame_max_d;
      frame_sum_q  <= frame_sum_d;
      frame_cnt_q  <= frame_cnt_d;
      order_err_q  <= order_err_d;
      gap_err_q    <= gap_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Frame sequencing, running accumulation and report publishing
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    min_d        = min_q;
    max_d        = max_q;
    prev_d       = prev_q;
    sum_d        = sum_q;
    ok_d         = ok_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    frame_min_d  = frame_min_q;
    frame_max_d  = frame_max_q;
    frame_sum_d  = frame_sum_q;
    frame_cnt_d  = frame_cnt_q;
    order_err_d  = 1'b0;
    gap_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          min_d   = in_data;
          max_d   = in_data;
          prev_d  = in_data;
          sum_d   = samp_ext_s;
          ok_d    = 1'b1;
          idx_d   = IW'(1);
          state_d = RECV;
        end else begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (in_valid) begin
          order_err_d = (in_data < prev_q);
          ok_d        = ok_q & ~order_err_d;
          min_d       = (in_data < min_q) ? in_data : min_q;
          max_d       = (in_data > max_q) ? in_data : max_q;
          sum_d       = sum_q + samp_ext_s;
          prev_d      = in_data;
          // Publish from the _d values so the last sample is included
          if (idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            frame_ok_d   = ok_d;
            frame_min_d  = min_d;
            frame_max_d  = max_d;
            frame_sum_d  = sum_d;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            idx_d        = {IW{1'b0}};
            state_d      = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          gap_err_d = 1'b1;
          idx_d     = {IW{1'b0}};
          state_d   = IDLE;
        end
      end
      default: begin
        idx_d   = {IW{1'b0}};
        state_d = IDLE;
      end
    endcase

    // A new error outranks a simultaneous clear
    if (order_err_d || gap_err_d) begin
      err_sticky_d = 1'b1;
    end else if (clear_err) begin
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q;
    end
  end

  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign frame_min  = frame_min_q;
  assign frame_max  = frame_max_q;
  assign frame_sum  = frame_sum_q;
  assign frame_cnt  = frame_cnt_q;
  assign order_err  = order_err_q;
  assign gap_err    = gap_err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_sorted_frame_checker.sv
// Self-checking bench for sorted_frame_checker: table-driven frames, hand-written
// corner sequences and randomized traffic against a queue-based frame model.
module tb_sorted_frame_checker;

  logic              CLK;
  logic              RESET;
  logic signed [7:0] in_data;
  logic              in_valid;
  logic              clear_err;
  logic              frame_done;
  logic              frame_ok;
  logic signed [7:0] frame_min;
  logic signed [7:0] frame_max;
  logic signed [10:0] frame_sum;
  logic [15:0]       frame_cnt;
  logic              order_err;
  logic              gap_err;
  logic              err_sticky;

  sorted_frame_checker dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .clear_err  (clear_err),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .frame_min  (frame_min),
    .frame_max  (frame_max),
    .frame_sum  (frame_sum),
    .frame_cnt  (frame_cnt),
    .order_err  (order_err),
    .gap_err    (gap_err),
    .err_sticky (err_sticky)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int oerr_seen = 0;
  int done_cycles[$];

  // Reference model: expected outputs after each clock edge
  int mq[$];
  int m_done, m_ok, m_min, m_max, m_sum, m_cnt, m_oerr, m_gerr, m_sticky;

  typedef struct {
    logic [0:7][7:0] s;
    int exp_ok;
    int exp_min;
    int exp_max;
    int exp_sum;
    int exp_oerr;
  } frame_vec_t;

  frame_vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit v, input int d, input bit c, input bit r);
    if (r) begin
      mq.delete();
      m_done = 0; m_ok = 0; m_min = 0; m_max = 0; m_sum = 0;
      m_cnt = 0; m_oerr = 0; m_gerr = 0; m_sticky = 0;
    end else begin
      m_done = 0; m_oerr = 0; m_gerr = 0;
      if (v) begin
        if (mq.size() > 0 && d < mq[$]) m_oerr = 1;
        mq.push_back(d);
        if (mq.size() == 8) begin
          m_ok = 1; m_min = mq[0]; m_max = mq[0]; m_sum = 0;
          foreach (mq[i]) begin
            if (i > 0 && mq[i] < mq[i-1]) m_ok = 0;
            if (mq[i] < m_min) m_min = mq[i];
            if (mq[i] > m_max) m_max = mq[i];
            m_sum += mq[i];
          end
          m_done = 1;
          m_cnt = (m_cnt + 1) & 32'hFFFF;
          mq.delete();
        end
      end else if (mq.size() > 0) begin
        m_gerr = 1;
        mq.delete();
      end
      if (m_oerr != 0 || m_gerr != 0) m_sticky = 1;
      else if (c) m_sticky = 0;
    end
  endtask

  task automatic compare_model();
    check("frame_done", int'(frame_done), m_done);
    check("frame_ok",   int'(frame_ok),   m_ok);
    check("frame_min",  int'(frame_min),  m_min);
    check("frame_max",  int'(frame_max),  m_max);
    check("frame_sum",  int'(frame_sum),  m_sum);
    check("frame_cnt",  int'(frame_cnt),  m_cnt);
    check("order_err",  int'(order_err),  m_oerr);
    check("gap_err",    int'(gap_err),    m_gerr);
    check("err_sticky", int'(err_sticky), m_sticky);
  endtask

  task automatic cycle(input bit v, input int d, input bit c, input bit r);
    in_valid  = v;
    in_data   = 8'(d);
    clear_err = c;
    RESET     = r;
    @(posedge CLK);
    model_step(v, d, c, r);
    #1;
    cyc++;
    compare_model();
    if (order_err) oerr_seen++;
    if (frame_done) done_cycles.push_back(cyc);
  endtask

  initial begin
    int cnt0;
    int prev;
    int d;
    bit v, c, r;

    in_valid = 1'b0; in_data = 8'sd0; clear_err = 1'b0; RESET = 1'b1;

    vecs[0].s = {8'(-3), 8'(-2), 8'(-1), 8'(0), 8'(1), 8'(2), 8'(3), 8'(4)};
    vecs[0].exp_ok = 1; vecs[0].exp_min = -3; vecs[0].exp_max = 4;
    vecs[0].exp_sum = 4; vecs[0].exp_oerr = 0;
    vecs[1].s = {8'd1, 8'd2, 8'd5, 8'd3, 8'd6, 8'd7, 8'd8, 8'd9};
    vecs[1].exp_ok = 0; vecs[1].exp_min = 1; vecs[1].exp_max = 9;
    vecs[1].exp_sum = 41; vecs[1].exp_oerr = 1;
    vecs[2].s = {8{8'h80}};
    vecs[2].exp_ok = 1; vecs[2].exp_min = -128; vecs[2].exp_max = -128;
    vecs[2].exp_sum = -1024; vecs[2].exp_oerr = 0;
    vecs[3].s = {8{8'h7F}};
    vecs[3].exp_ok = 1; vecs[3].exp_min = 127; vecs[3].exp_max = 127;
    vecs[3].exp_sum = 1016; vecs[3].exp_oerr = 0;

    // Reset state
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("rst_done", int'(frame_done), 0);
    check("rst_cnt", int'(frame_cnt), 0);
    check("rst_sum", int'(frame_sum), 0);
    check("rst_sticky", int'(err_sticky), 0);
    cycle(1'b0, 0, 1'b0, 1'b0);

    // Table-driven frames, back to back
    for (int vi = 0; vi < 4; vi++) begin
      oerr_seen = 0;
      for (int k = 0; k < 8; k++) cycle(1'b1, int'($signed(vecs[vi].s[k])), 1'b0, 1'b0);
      check("tbl_done", int'(frame_done), 1);
      check("tbl_ok",   int'(frame_ok),   vecs[vi].exp_ok);
      check("tbl_min",  int'(frame_min),  vecs[vi].exp_min);
      check("tbl_max",  int'(frame_max),  vecs[vi].exp_max);
      check("tbl_sum",  int'(frame_sum),  vecs[vi].exp_sum);
      check("tbl_oerr", oerr_seen,        vecs[vi].exp_oerr);
      check("tbl_cnt",  int'(frame_cnt),  vi + 1);
    end
    check("tbl_sticky", int'(err_sticky), 1);
    cycle(1'b0, 0, 1'b1, 1'b0);
    check("clear_sticky", int'(err_sticky), 0);

    // Gap mid-frame, then a clean frame
    cnt0 = int'(frame_cnt);
    for (int k = 0; k < 3; k++) cycle(1'b1, k + 1, 1'b0, 1'b0);
    cycle(1'b0, 99, 1'b0, 1'b0);
    check("gap_pulse", int'(gap_err), 1);
    check("gap_nodone", int'(frame_done), 0);
    check("gap_cnt", int'(frame_cnt), cnt0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    check("gap_one_cycle", int'(gap_err), 0);
    for (int k = 0; k < 8; k++) cycle(1'b1, k, 1'b0, 1'b0);
    check("gap_next_done", int'(frame_done), 1);
    check("gap_next_ok", int'(frame_ok), 1);
    check("gap_next_sum", int'(frame_sum), 28);
    check("gap_next_cnt", int'(frame_cnt), cnt0 + 1);

    // 16 consecutive samples: two frames, reports 8 cycles apart
    cnt0 = int'(frame_cnt);
    done_cycles.delete();
    for (int k = 0; k < 16; k++) cycle(1'b1, (k % 8) - 4, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    check("b2b_pulses", done_cycles.size(), 2);
    if (done_cycles.size() == 2) check("b2b_spacing", done_cycles[1] - done_cycles[0], 8);
    check("b2b_cnt", int'(frame_cnt), cnt0 + 2);

    // Reset at sample 5, then a full frame
    for (int k = 0; k < 5; k++) cycle(1'b1, k, 1'b0, 1'b0);
    cycle(1'b1, 5, 1'b0, 1'b1);
    done_cycles.delete();
    for (int k = 0; k < 8; k++) cycle(1'b1, 10 + k, 1'b0, 1'b0);
    check("rstmid_pulses", done_cycles.size(), 1);
    check("rstmid_sum", int'(frame_sum), 108);
    check("rstmid_min", int'(frame_min), 10);
    check("rstmid_max", int'(frame_max), 17);
    check("rstmid_cnt", int'(frame_cnt), 1);

    // clear_err in the same cycle as an order violation
    cycle(1'b1, 5, 1'b0, 1'b0);
    cycle(1'b1, 4, 1'b1, 1'b0);
    check("clr_vs_err_pulse", int'(order_err), 1);
    check("clr_vs_err_sticky", int'(err_sticky), 1);
    for (int k = 0; k < 6; k++) cycle(1'b1, 6 + k, 1'b0, 1'b0);
    check("clr_vs_err_ok", int'(frame_ok), 0);

    // Randomized traffic, mostly sorted runs
    prev = -128;
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 19) != 0);
      c = ($urandom_range(0, 29) == 0);
      r = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) == 0) begin
        d = int'($urandom_range(0, 255)) - 128;
      end else begin
        d = prev + int'($urandom_range(0, 20));
        if (d > 127) d = int'($urandom_range(0, 255)) - 128;
      end
      if (v) prev = d;
      cycle(v, d, c, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sorted_frame_checker.md
# sorted_frame_checker

Receive-side monitor for the 8-bit signed number sorter's output stream. It consumes the serial `out`/`out_valid` burst, one frame of FRAME_LEN samples, and checks that each frame is non-decreasing and contiguous. Per frame it reports min, max, sum and a pass flag, and it keeps a running frame count and a sticky error flag. It sits directly on the sorter's output, in silicon as a self-check and in benches as the scoreboard front end.

## Interface
- FRAME_LEN, 8: samples per frame, 2..16.
- DW, 8: sample width, two's complement.
- SW, DW+$clog2(FRAME_LEN): sum width, 11 at defaults.
- CLK  in  1  clock, rising edge.
- RESET  in  1  reset, synchronous, active-high; clock CLK.
- in_data  in  DW  signed sample, driven by the sorter's `out`.
- in_valid  in  1  sample qualifier, driven by the sorter's `out_valid`.
- clear_err  in  1  clears err_sticky.
- frame_done  out  1  one-cycle pulse: a frame completed.
- frame_ok  out  1  valid with frame_done: 1 = no order violation in the frame.
- frame_min / frame_max  out  DW  signed minimum and maximum of the last completed frame.
- frame_sum  out  SW  signed exact sum of the last completed frame.
- frame_cnt  out  16  completed frames, wraps at 0xFFFF→0.
- order_err  out  1  one-cycle pulse: sample smaller than its predecessor.
- gap_err  out  1  one-cycle pulse: in_valid dropped mid-frame.
- err_sticky  out  1  OR of all order_err/gap_err since the last clear or reset.

## Operation
- States: IDLE (idx=0, no frame open) and RECV (idx=1..FRAME_LEN-1).
- IDLE + in_valid: accept sample 0. Load min=max=sum=sample and prev=sample, set ok=1, idx=1, go to RECV. IDLE with in_valid=0: hold.
- RECV + in_valid: accept sample idx.
  - sample<prev: ok←0 and pulse order_err. Equal samples are legal.
  - Update min, max and sum (sign-extend sample to SW; no overflow possible), then prev←sample.
- If idx=FRAME_LEN-1 (last sample):
  - Publish min/max/sum/ok to the outputs and pulse frame_done.
  - frame_cnt+1; go to IDLE.
  - Otherwise idx+1.
- RECV + !in_valid: pulse gap_err, discard the partial frame, go to IDLE. There is no frame_done, and outputs and frame_cnt are unchanged.
- Back-to-back frames: a valid sample in the cycle after the last sample is sample 0 of the next frame, with no dead cycle required.
- err_sticky sets on any order_err or gap_err. If clear_err is asserted in the same cycle as a new error, the error wins and err_sticky stays 1.
- in_data is ignored whenever in_valid=0.

## Timing
- Reset values: frame_done=0, frame_ok=0, frame_min=0, frame_max=0, frame_sum=0, frame_cnt=0, order_err=0, gap_err=0, err_sticky=0, state IDLE, idx=0.
- RESET mid-frame discards the partial frame. The first sample after RESET deasserts is sample 0.
- All outputs are registered.
- order_err rises in the cycle after the edge that accepts the offending sample.
- gap_err rises in the cycle after the first edge with in_valid=0 in RECV.
- frame_done/frame_ok rise in the cycle after the edge that accepts the last sample. frame_cnt, min, max and sum update on that same edge.
- frame_min/max/sum/ok hold their value until the next frame_done.
- Latency from last sample to report: 1 cycle. Throughput: 1 sample per cycle, sustained.
- The sorter's idle cycle after its 8-sample burst (out_valid=0) is legal in IDLE.

## Structure
- Shared package `sorter_pkg`: DW, FRAME_LEN and derived SW, the `sample_t` signed typedef, and the state enum {IDLE, RECV}.
- Single module with no sub-modules. The min/max/sum accumulator is inline; it is too small to split out.

## Test plan
- Sorted frame -3,-2,-1,0,1,2,3,4 → one frame_done with frame_ok=1, min=-3, max=4, sum=4, frame_cnt=1, no error pulses.
- Frame 1,2,5,3,6,7,8,9 → order_err pulse one cycle after the 4th sample; frame_done with frame_ok=0; err_sticky=1; sum=41.
- Three valid samples, then in_valid=0 → gap_err pulse, no frame_done, frame_cnt unchanged; the next 8 valid samples form a clean frame.
- Eight samples of -128 → frame_ok=1, min=max=-128, sum=-1024. Eight samples of 127 → sum=1016.
- 16 consecutive valid samples (two sorted frames) → two frame_done pulses exactly 8 cycles apart, frame_cnt=2.
- RESET at sample 5, then a full frame → one frame_done with the post-reset values. Separately: clear_err asserted in the same cycle as an order_err → err_sticky=1.
